mips32_mem_arbiter: RTL
=======================

MIPS32_MEM_ARBITER -- requirements
Module: mips32_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, word-address width (1024-word memory).
REQ-002 SHALL have parameter DATA_W, default 32, data word width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4, consecutive lost-arbitration cycles before the IF port is forced to win.
REQ-004 SHALL have port clk1  in  1  single clock, all state updates on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-006 SHALL have ports if_req in 1, if_addr in ADDR_W: instruction-fetch read request and address.
REQ-007 SHALL have ports if_gnt out 1, if_valid out 1, if_rdata out DATA_W: fetch grant pulse, read-data-valid pulse, read data.
REQ-008 SHALL have ports dm_req in 1, dm_we in 1, dm_addr in ADDR_W, dm_wdata in DATA_W: data-memory request, write enable, address, write data.
REQ-009 SHALL have ports dm_gnt out 1, dm_valid out 1, dm_rdata out DATA_W: data grant pulse, completion pulse (reads and writes), read data.
REQ-010 SHALL have ports mem_en out 1, mem_we out 1, mem_addr out ADDR_W, mem_wdata out DATA_W, mem_rdata in DATA_W: single-port memory interface, 1-cycle read latency.
REQ-011 SHALL have port halt_i  in  1  pipeline HALTED flag; blocks new grants.
REQ-012 SHALL have port conflict_cnt  out  16  saturating count of cycles with both requests pending.

Function
REQ-013 SHALL sample requests at edge N, drive registered grant and memory signals during cycle N+1, and pulse valid with rdata during cycle N+2.
REQ-014 SHALL grant at most one port per cycle; mem_en high exactly in cycles where a grant pulse is high.
REQ-015 SHALL accept a new request every cycle (full throughput, no bubble between back-to-back grants).
REQ-016 Requester SHALL hold req and address/data stable until its gnt; the arbiter SHALL ignore request inputs that are dropped before grant.
REQ-017 SHALL give dm priority when both request, unless starve_cnt == STARVE_LIMIT, in which case if wins.
REQ-018 starve_cnt SHALL increment when if_req is pending and not granted, clear on IF grant or if_req low, and never exceed STARVE_LIMIT.
REQ-019 if port SHALL always drive mem_we = 0; dm port SHALL drive mem_we = dm_we and mem_wdata = dm_wdata.
REQ-020 dm_valid SHALL pulse for writes as completion ack; dm_rdata is don't-care on write completions.
REQ-021 if_rdata/dm_rdata SHALL present mem_rdata only in their valid cycle and SHALL hold the last value otherwise.
REQ-022 FSM states: IDLE (no grant), GNT_IF, GNT_DM, HALT; next state computed from requests, priority rule and halt_i each cycle.
REQ-023 halt_i high SHALL move the FSM to HALT: no new grants; an access already granted SHALL still complete its valid pulse; halt_i low returns to IDLE.
REQ-024 conflict_cnt SHALL increment when if_req and dm_req are both high and the FSM is not in HALT; it SHALL saturate at 16'hFFFF.
REQ-025 Equal addresses on both ports SHALL need no special handling; ordering follows grant order.

Reset
REQ-026 With rst_n low at an edge: FSM = IDLE, starve_cnt = 0, conflict_cnt = 0, all gnt/valid/mem_en/mem_we = 0, mem_addr/mem_wdata/rdata outputs = 0.
REQ-027 Reset mid-access SHALL abort the pending valid pulse; no valid SHALL appear after reset deassertion without a new grant.

Structure
REQ-028 Shared package mips32_pkg SHALL hold the FSM state enum, port-select encoding (PORT_IF, PORT_DM) and default widths.
REQ-029 Sub-module mips32_starve_ctr SHALL implement the saturating starvation counter; remaining logic stays in the top.

Verification
REQ-030 Single IF read: mem[5]=32'h14431000, if_req with if_addr=5 -> if_gnt in cycle N+1, if_valid with if_rdata=32'h14431000 in N+2.
REQ-031 DM write then read: dm write addr 198 data 5040, then read 198 -> two dm_gnt on consecutive cycles, dm_valid twice, second dm_rdata = 5040.
REQ-032 Contention: if_req and dm_req held high continuously, dm re-requesting each cycle -> dm wins 4 cycles, if wins 5th; pattern repeats; conflict_cnt increments every cycle.
REQ-033 Halt: assert halt_i the cycle after dm_gnt -> that dm_valid still pulses; no gnt while halt_i high despite held requests; grants resume the cycle after halt_i drops.
REQ-034 Reset mid-access: rst_n low in the cycle after if_gnt -> no if_valid, all outputs 0, starve_cnt and conflict_cnt 0.
REQ-035 Saturation: force both requests for 70000 cycles -> conflict_cnt stops at 16'hFFFF.

Source files
------------

// File: rtl/mips32_pkg.sv
// Shared types and default widths for the MIPS32 memory arbiter slice.
package mips32_pkg;

  localparam int ADDR_W_DEF       = 10;
  localparam int DATA_W_DEF       = 32;
  localparam int STARVE_LIMIT_DEF = 4;
  localparam int CONFLICT_W       = 16;

  // Arbiter state: the grant states double as the registered grant pulse.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GNT_IF = 2'd1,
    ST_GNT_DM = 2'd2,
    ST_HALT   = 2'd3
  } arb_state_t;

  // Which requester drives the memory command for a grant.
  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_DM = 1'b1
  } port_sel_t;

endpackage

// File: rtl/mips32_starve_ctr.sv
// Saturating count of consecutive cycles the fetch port waited without a grant.
module mips32_starve_ctr
  import mips32_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic clk1,
  input  logic rst_n,
  input  logic if_req,
  input  logic if_win,
  output logic at_limit
);

  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;

  // Count waiting cycles; clear when fetch wins or stops requesting; stop at the limit.
  always_ff @(posedge clk1) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // updates from pre-edge values regardless of statement order.
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!if_req || if_win) begin
      starve_cnt <= '0;
    end else if (starve_cnt != LIMIT) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

  assign at_limit = (starve_cnt == LIMIT);

endmodule

// File: rtl/mips32_mem_arbiter.sv
// Two-port (fetch / data) arbiter in front of a single-port, 1-cycle-latency memory.
// Requests sampled at edge N, grant + memory command in cycle N+1, valid + data in N+2.
module mips32_mem_arbiter
  import mips32_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic                  clk1,
  input  logic                  rst_n,
  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  output logic                  if_gnt,
  output logic                  if_valid,
  output logic [DATA_W-1:0]     if_rdata,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [ADDR_W-1:0]     dm_addr,
  input  logic [DATA_W-1:0]     dm_wdata,
  output logic                  dm_gnt,
  output logic                  dm_valid,
  output logic [DATA_W-1:0]     dm_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  halt_i,
  output logic [CONFLICT_W-1:0] conflict_cnt
);

  arb_state_t          state, next_state;
  port_sel_t           grant_sel;
  logic                grant_en;
  logic                if_win;
  logic                starve_at_limit;
  logic [DATA_W-1:0]   if_rdata_hold, dm_rdata_hold;

  mips32_starve_ctr #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve_ctr (
    .clk1     (clk1),
    .rst_n    (rst_n),
    .if_req   (if_req),
    .if_win   (if_win),
    .at_limit (starve_at_limit)
  );

  // Next state: halt blocks grants; data port wins ties unless fetch has starved.
  // Leaving HALT arbitrates immediately so grants resume the cycle after halt_i drops.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    next_state = ST_IDLE;
    grant_sel  = PORT_DM;
    grant_en   = 1'b0;
    if (halt_i) begin
      next_state = ST_HALT;
    end else if (if_req && (!dm_req || starve_at_limit)) begin
      next_state = ST_GNT_IF;
      grant_sel  = PORT_IF;
      grant_en   = 1'b1;
    end else if (dm_req) begin
      next_state = ST_GNT_DM;
      grant_en   = 1'b1;
    end
  end

  assign if_win = (next_state == ST_GNT_IF);

  // State register; the grant states are the registered grant pulses.
  always_ff @(posedge clk1) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  assign if_gnt = (state == ST_GNT_IF);
  assign dm_gnt = (state == ST_GNT_DM);
  assign mem_en = if_gnt | dm_gnt;

  // Register the winning port's memory command alongside its grant.
  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= 1'b0;
      if (grant_en) begin
        case (grant_sel)
          PORT_IF: mem_addr <= if_addr;
          PORT_DM: begin
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            mem_we    <= dm_we;
          end
          default: mem_we <= 1'b0;
        endcase
      end
    end
  end

  // Valid pulses one cycle after the grant; remember read data for the hold behaviour.
  always_ff @(posedge clk1) begin
    // NOTE: the hold registers are reset so read-data outputs are 0 out of reset
    // and a reset mid-access cancels the pending valid pulse.
    if (!rst_n) begin
      if_valid      <= 1'b0;
      dm_valid      <= 1'b0;
      if_rdata_hold <= '0;
      dm_rdata_hold <= '0;
    end else begin
      if_valid <= if_gnt;
      dm_valid <= dm_gnt;
      if (if_valid) if_rdata_hold <= mem_rdata;
      if (dm_valid) dm_rdata_hold <= mem_rdata;
    end
  end

  assign if_rdata = if_valid ? mem_rdata : if_rdata_hold;
  assign dm_rdata = dm_valid ? mem_rdata : dm_rdata_hold;

  // Saturating count of cycles where both ports request outside HALT.
  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      conflict_cnt <= '0;
    end else if (if_req && dm_req && (state != ST_HALT) &&
                 (conflict_cnt != {CONFLICT_W{1'b1}})) begin
      conflict_cnt <= conflict_cnt + CONFLICT_W'(1);
    end
  end

endmodule
